// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants used by fetch, the fetch queue and decode.
package fetch_pkg;

    localparam int FQ_DEPTH = 8;
    localparam int XLEN     = 32;
    localparam int INST_W   = 32;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction fetch buffer between fetch and decode/rename.
// First-word fall-through dequeue, count-based full/empty, flush clears all entries.
module fetch_queue #(
    parameter int DEPTH  = fetch_pkg::FQ_DEPTH,
    parameter int XLEN   = fetch_pkg::XLEN,
    parameter int INST_W = fetch_pkg::INST_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [INST_W-1:0]        enq_inst,
    input  logic                     enq_pred_taken,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_pc,
    output logic [INST_W-1:0]        deq_inst,
    output logic                     deq_pred_taken,
    output logic [$clog2(DEPTH):0]   count
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    fetch_entry_t  mem_r [DEPTH];

    logic          enq_fire_s;
    logic          deq_fire_s;
    fetch_entry_t  enq_entry_s;
    fetch_entry_t  head_entry_s;

    // Handshake qualification; flush gates both sides so nothing moves in a flush cycle.
    always_comb begin
        enq_ready   = 1'b0;
        deq_valid   = 1'b0;
        enq_fire_s  = 1'b0;
        deq_fire_s  = 1'b0;
        enq_entry_s = '{pc: enq_pc, inst: enq_inst, pred_taken: enq_pred_taken};
        if (flush) begin
            enq_ready = 1'b0;
            deq_valid = 1'b0;
        end else begin
            enq_ready = (count_r != FULL_CNT);
            deq_valid = (count_r != ZERO_CNT);
        end
        enq_fire_s = enq_valid && enq_ready;
        deq_fire_s = deq_valid && deq_ready;
    end

    // Head/tail pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= ZERO_CNT;
        end else if (flush) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= ZERO_CNT;
        end else begin
            if (enq_fire_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (deq_fire_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; left unreset since count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            mem_r[tail_r] <= enq_entry_s;
        end
    end

    // Fall-through head view, forced to zero when the queue is empty.
    always_comb begin
        head_entry_s   = mem_r[head_r];
        deq_pc         = {XLEN{1'b0}};
        deq_inst       = {INST_W{1'b0}};
        deq_pred_taken = 1'b0;
        if (count_r != ZERO_CNT) begin
            deq_pc         = head_entry_s.pc;
            deq_inst       = head_entry_s.inst;
            deq_pred_taken = head_entry_s.pred_taken;
        end else begin
            deq_pc         = {XLEN{1'b0}};
            deq_inst       = {INST_W{1'b0}};
            deq_pred_taken = 1'b0;
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes accepted entries, a negedge monitor checks and pops.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pt;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_pc = 32'h0;
    logic [31:0] enq_inst = 32'h0;
    logic        enq_pred_taken = 1'b0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic        deq_pred_taken;
    logic [3:0]  count;

    int   n_cmp = 0;
    int   n_fail = 0;
    ent_t exp_q[$];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .INST_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_pred_taken(enq_pred_taken),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_pred_taken(deq_pred_taken),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Monitor: compares DUT against the reference queue and retires the head on a modelled dequeue.
    initial begin
        forever begin
            int   sz;
            ent_t hd;
            @(negedge clk);
            sz = exp_q.size();
            if (!reset) begin
                chk("rst_count", 64'(count), 64'd0);
                chk("rst_deq_valid", 64'(deq_valid), 64'd0);
                chk("rst_enq_ready", 64'(enq_ready), 64'd1);
                chk("rst_deq_pc", 64'(deq_pc), 64'd0);
                chk("rst_deq_inst", 64'(deq_inst), 64'd0);
            end else begin
                chk("count", 64'(count), 64'(sz));
                chk("enq_ready", 64'(enq_ready), 64'((sz != DEPTH) && !flush));
                chk("deq_valid", 64'(deq_valid), 64'((sz != 0) && !flush));
                if (sz == 0) begin
                    chk("empty_pc", 64'(deq_pc), 64'd0);
                    chk("empty_inst", 64'(deq_inst), 64'd0);
                    chk("empty_pt", 64'(deq_pred_taken), 64'd0);
                end else if (!flush) begin
                    hd = exp_q[0];
                    chk("deq_pc", 64'(deq_pc), 64'(hd.pc));
                    chk("deq_inst", 64'(deq_inst), 64'(hd.inst));
                    chk("deq_pt", 64'(deq_pred_taken), 64'(hd.pt));
                    if (deq_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic ev, input logic [31:0] pc, input logic [31:0] inst,
                       input logic pt, input logic dr, input logic fl, output logic fired);
        ent_t e;
        enq_valid      = ev;
        enq_pc         = pc;
        enq_inst       = inst;
        enq_pred_taken = pt;
        deq_ready      = dr;
        flush          = fl;
        fired = ev && (exp_q.size() != DEPTH) && !fl;
        e = '{pc: pc, inst: inst, pt: pt};
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (fired) exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        logic        f;
        logic        have;
        logic [31:0] p_pc;
        logic [31:0] p_inst;
        logic        p_pt;
        logic        ev;
        logic        dr;
        logic        fl;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset in the middle of operation with three entries queued
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 32'(i), 1'b0, 1'b0, 1'b0, f);
        do_reset(2);
        cyc(1'b1, 32'h0000_0100, 32'h0000_0013, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, f);

        // Fill to full, attempt a ninth entry, then drain
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'(i % 2), 1'b0, 1'b0, f);
        cyc(1'b1, 32'h120, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0, f);
        cyc(1'b1, 32'h120, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0, f);
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);

        // Steady state at count 4 with both sides firing, across pointer wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h300 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, f);
        for (int i = 0; i < 20; i++) cyc(1'b1, 32'h400 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0, f);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);

        // Flush at count 5 with enq and deq presented in the same cycle
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b1, 32'hDEAD_0000, 32'h0BAD_0BAD, 1'b1, 1'b1, 1'b1, f);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);
        cyc(1'b1, 32'h600, 32'h0000_0033, 1'b0, 1'b0, 1'b0, f);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, f);

        // Backpressure: head 0x200 with pred_taken held while new entries arrive
        cyc(1'b1, 32'h200, 32'h0000_0063, 1'b1, 1'b0, 1'b0, f);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h204 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0, f);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);

        // Randomized traffic; fetch holds an entry until it is accepted
        have = 1'b0;
        p_pc = 32'h0;
        p_inst = 32'h0;
        p_pt = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset(1);
            if (!have) begin
                p_pc   = $urandom & 32'hFFFF_FFFC;
                p_inst = $urandom;
                p_pt   = 1'($urandom_range(0, 1));
                have   = 1'b1;
            end
            ev = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            cyc(ev, p_pc, p_inst, p_pt, dr, fl, f);
            if (f || fl) have = 1'b0;
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, f);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
